serial_fullsubtractor: RTL

//   Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.

---
 rtl/serial_fullsubtractor_if.sv | 33 +++
 rtl/serial_fullsubtractor.sv | 98 +++++++++
 2 files changed

// File: rtl/serial_fullsubtractor_if.sv
// Start/done handshake bundle between a sequencing controller and the bit-serial subtractor.
// The controller drives operands and start; the subtractor returns status and the result.
interface serial_fullsubtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  borrow_out
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output borrow_out
    );
endinterface

// File: rtl/serial_fullsubtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, one full-subtractor cell plus a borrow flop.
// state | meaning
// IDLE  | waiting for start; operands are latched when start is seen
// SHIFT | one bit per clock through the full-subtractor cell, WIDTH cycles
// DONE  | publish diff/borrow_out and pulse done, then back to IDLE
module serial_fullsubtractor #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_fullsubtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_b;

    // Returns {borrow, difference} of x - y.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

    // Two cascaded half-subtractors; either stage borrowing means the bit borrows.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_sub(x, y);
        h2 = half_sub(h1[0], bin);
        return {h1[1] | h2[1], h2[0]};
    endfunction

    assign {cell_b, cell_d} = full_sub(sa[0], sb[0], br);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sa             <= '0;
            sb             <= '0;
            res            <= '0;
            br             <= 1'b0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        res      <= '0;
                        br       <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // LSB-first bits enter at the MSB so they land in place after WIDTH shifts.
                    res <= {cell_d, res[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= cell_b;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.diff       <= res;
                    bus.borrow_out <= br;
                    bus.done       <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
